// File: rtl/spi_pkg.sv
// spi_pkg: shared types and default sizing for the SPI master.
//   state_t        : frame sequencer states
//   FRAME_BITS_DEF : default bits per SSEL frame
//   CLK_DIV_DEF    : default clk cycles per SCK half-period
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam int FRAME_BITS_DEF = 88;
  localparam int CLK_DIV_DEF    = 4;

endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: SCK generator for the SPI master.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   en   : run SCK; while low SCK is parked low and the divider is preloaded
//   sck  : SPI clock, CLK_DIV clk cycles per half-period
//   rise : high on the clk cycle whose edge drives SCK high
//   fall : high on the clk cycle whose edge drives SCK low
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;
  logic       tc;

  assign tc   = en && (div_cnt == 8'd0);
  assign rise = tc && !sck;
  assign fall = tc && sck;

  // Preloading while disabled makes the first toggle land exactly
  // CLK_DIV cycles after en rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= 8'd0;
      sck     <= 1'b0;
    end else if (!en) begin
      div_cnt <= RELOAD;
      sck     <= 1'b0;
    end else if (tc) begin
      div_cnt <= RELOAD;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// spi_master: frame-based SPI master, mode 0 (SCK idle low, sample on rise).
//   clk, rst        : system clock, asynchronous active-high reset
//   start, tx_data  : frame request (sampled while idle) and frame, MSB first
//   busy, done      : frame in progress incl. gap; one-cycle completion pulse
//   rx_data         : last captured MISO frame, MSB first
//   SCK, MOSI, SSEL : SPI bus outputs (SSEL active low)
//   MISO            : SPI bus input
// Build option: define SPI_MASTER_RX_EN to capture MISO into rx_data;
// otherwise rx_data is tied to zero and MISO is ignored.
//
// state | meaning
// IDLE  | SSEL high, waiting for start
// SETUP | SSEL low, MOSI shows MSB, one half-period before first rise
// SHIFT | SCK running, MOSI advances on each fall
// HOLD  | SSEL kept low one half-period after the last fall
// GAP   | SSEL high one half-period, busy still set; start accepted at end
module spi_master
  import spi_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int CLK_DIV    = CLK_DIV_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  SCK,
  output logic                  MOSI,
  output logic                  SSEL,
  input  logic                  MISO
);

  localparam int             BCW      = $clog2(FRAME_BITS + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_BITS - 1);
  localparam logic [7:0]     RELOAD   = 8'(CLK_DIV - 1);

  state_t                state, state_n;
  logic [FRAME_BITS-1:0] tx_sh, tx_sh_n;
  logic [BCW-1:0]        bit_cnt, bit_cnt_n;
  logic [7:0]            tmr, tmr_n;
  logic                  ssel_n, busy_n, done_n, mosi_n;
  logic                  accept, sck_en, rise, fall;

  assign sck_en = (state == SETUP) || (state == SHIFT);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (sck_en),
    .sck  (SCK),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx_sh   <= '0;
      bit_cnt <= '0;
      tmr     <= 8'd0;
      SSEL    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      MOSI    <= 1'b0;
    end else begin
      state   <= state_n;
      tx_sh   <= tx_sh_n;
      bit_cnt <= bit_cnt_n;
      tmr     <= tmr_n;
      SSEL    <= ssel_n;
      busy    <= busy_n;
      done    <= done_n;
      MOSI    <= mosi_n;
    end
  end

  always_comb begin
    state_n   = state;
    tx_sh_n   = tx_sh;
    bit_cnt_n = bit_cnt;
    tmr_n     = tmr;
    ssel_n    = SSEL;
    busy_n    = busy;
    done_n    = 1'b0;
    mosi_n    = MOSI;
    accept    = 1'b0;

    case (state)
      IDLE: begin
        if (start) accept = 1'b1;
      end
      SETUP: begin
        if (rise) state_n = SHIFT;
      end
      SHIFT: begin
        if (fall) begin
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            // MOSI keeps the final bit through HOLD.
            state_n = HOLD;
            tmr_n   = RELOAD;
          end else begin
            tx_sh_n = tx_sh << 1;
            mosi_n  = tx_sh[FRAME_BITS-2];
          end
        end
      end
      HOLD: begin
        if (tmr == 8'd0) begin
          state_n = GAP;
          ssel_n  = 1'b1;
          done_n  = 1'b1;
          tmr_n   = RELOAD;
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      GAP: begin
        if (tmr == 8'd0) begin
          // Accepting here instead of via IDLE keeps the SSEL-high gap
          // at exactly CLK_DIV cycles for back-to-back frames.
          if (start) begin
            accept = 1'b1;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (accept) begin
      state_n   = SETUP;
      ssel_n    = 1'b0;
      busy_n    = 1'b1;
      tx_sh_n   = tx_data;
      mosi_n    = tx_data[FRAME_BITS-1];
      bit_cnt_n = '0;
    end
  end

`ifdef SPI_MASTER_RX_EN
  logic [FRAME_BITS-1:0] rx_sh;
  logic                  frame_end;

  assign frame_end = (state == HOLD) && (tmr == 8'd0);

  // Exactly FRAME_BITS rises per frame flush the whole shifter, so no clear
  // is needed between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sh   <= '0;
      rx_data <= '0;
    end else begin
      if (rise)      rx_sh   <= {rx_sh[FRAME_BITS-2:0], MISO};
      if (frame_end) rx_data <= rx_sh;
    end
  end
`else
  logic unused_miso;
  assign unused_miso = MISO;
  assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
module tb_spi_master;

  localparam int F  = 8;
  localparam int D  = 4;
  localparam int FL = 88;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [F-1:0]  tx_data = '0;
  logic          busy, done, sck, mosi, ssel, miso;
  logic [F-1:0]  rx_data;

  logic          start88 = 1'b0;
  logic [FL-1:0] tx88 = '0;
  logic          busy88, done88, sck88, mosi88, ssel88, miso88;
  logic [FL-1:0] rx88;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // slave model state
  bit            loop = 1'b1;
  logic [F-1:0]  miso_vec = '0;
  logic [FL-1:0] mv88 = '0;
  int            nrise = 0;
  int            nr88 = 0;

  // recorded bus events (edge index of the change)
  int rise_t[$], fall_t[$], lo_t[$], hi_t[$], done_t[$], bfall_t[$];
  bit mosi_q[$];
  logic sck_q = 1'b0, ssel_q = 1'b1, busy_q = 1'b0;
  logic [FL-1:0] mosi88_acc = '0;
  logic sck88_q = 1'b0, ssel88_q = 1'b1;
  int done88_n = 0;

  spi_master #(.FRAME_BITS(F), .CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data),
    .SCK(sck), .MOSI(mosi), .SSEL(ssel), .MISO(miso)
  );

  spi_master dut88 (
    .clk(clk), .rst(rst), .start(start88), .tx_data(tx88),
    .busy(busy88), .done(done88), .rx_data(rx88),
    .SCK(sck88), .MOSI(mosi88), .SSEL(ssel88), .MISO(miso88)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave presents bit k of its word before SCK rise k.
  assign miso   = loop ? mosi : ((nrise < F) ? miso_vec[F-1-nrise] : 1'b0);
  assign miso88 = (nr88 < FL) ? mv88[FL-1-nr88] : 1'b0;

  always @(negedge clk) begin
    if (sck && !sck_q) begin
      rise_t.push_back(cyc);
      mosi_q.push_back(mosi);
      nrise++;
    end
    if (!sck && sck_q) fall_t.push_back(cyc);
    if (!ssel && ssel_q) begin
      lo_t.push_back(cyc);
      nrise = 0;
    end
    if (ssel && !ssel_q) hi_t.push_back(cyc);
    if (done) done_t.push_back(cyc);
    if (!busy && busy_q) bfall_t.push_back(cyc);
    sck_q  = sck;
    ssel_q = ssel;
    busy_q = busy;

    if (sck88 && !sck88_q) begin
      mosi88_acc = {mosi88_acc[FL-2:0], mosi88};
      nr88++;
    end
    if (!ssel88 && ssel88_q) nr88 = 0;
    if (done88) done88_n++;
    sck88_q  = sck88;
    ssel88_q = ssel88;
  end

  task automatic clear_mon();
    rise_t.delete(); fall_t.delete(); lo_t.delete(); hi_t.delete();
    done_t.delete(); bfall_t.delete(); mosi_q.delete();
  endtask

  // Count of frame-j events deviating from the ideal schedule for a frame
  // accepted at edge e.
  function automatic int timing_errs(input int e, input int j);
    int n = 0;
    if (rise_t.size() < (j+1)*F || fall_t.size() < (j+1)*F ||
        lo_t.size() <= j || hi_t.size() <= j || done_t.size() <= j)
      return 1000;
    for (int k = 0; k < F; k++) begin
      if (rise_t[j*F+k] != e + D + 2*k*D) n++;
      if (fall_t[j*F+k] != e + 2*(k+1)*D) n++;
    end
    if (lo_t[j]   != e)               n++;
    if (hi_t[j]   != e + 2*F*D + D)   n++;
    if (done_t[j] != e + 2*F*D + D)   n++;
    return n;
  endfunction

  function automatic int mosi_errs(input logic [F-1:0] tx, input int j);
    int n = 0;
    int v = int'(tx);
    if (mosi_q.size() < (j+1)*F) return 1000;
    for (int k = 0; k < F; k++)
      if (mosi_q[j*F+k] != bit'((v >> (F-1-k)) & 1)) n++;
    return n;
  endfunction

  function automatic logic [F-1:0] exp_rx(input logic [F-1:0] tx, input logic [F-1:0] mv, input bit lp);
    logic [F-1:0] r;
    r = lp ? tx : mv;
`ifndef SPI_MASTER_RX_EN
    r = '0;
`endif
    return r;
  endfunction

  task automatic send_frame(input logic [F-1:0] tx, output int e);
    @(negedge clk);
    tx_data = tx;
    start   = 1'b1;
    e       = cyc + 1;
    @(negedge clk);
    start   = 1'b0;
    tx_data = ~tx;
    repeat (2*F*D + 2*D + 4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (sck !== 1'b0)   $display("FAIL reset_sck: got %b want 0", sck);   else n_pass++;
    n_chk++; if (ssel !== 1'b1)  $display("FAIL reset_ssel: got %b want 1", ssel); else n_pass++;
    n_chk++; if (mosi !== 1'b0)  $display("FAIL reset_mosi: got %b want 0", mosi); else n_pass++;
    n_chk++; if (busy !== 1'b0)  $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0)  $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_chk++; if (rx_data !== '0) $display("FAIL reset_rx: got %h want 0", rx_data); else n_pass++;
    n_chk++; if (ssel88 !== 1'b1) $display("FAIL reset_ssel88: got %b want 1", ssel88); else n_pass++;
    n_chk++; if (rx88 !== '0)    $display("FAIL reset_rx88: got %h want 0", rx88); else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_mon();
  endtask

  task automatic test_loopback();
    int e, te, me;
    loop = 1'b1;
    clear_mon();
    send_frame(8'hA5, e);
    te = timing_errs(e, 0);
    me = mosi_errs(8'hA5, 0);
    n_chk++; if (te !== 0) $display("FAIL loop_timing: %0d events off", te); else n_pass++;
    n_chk++; if (me !== 0) $display("FAIL loop_mosi: %0d bits wrong", me); else n_pass++;
    n_chk++; if (rx_data !== exp_rx(8'hA5, '0, 1'b1))
      $display("FAIL loop_rx: got %h want %h", rx_data, exp_rx(8'hA5, '0, 1'b1)); else n_pass++;
    n_chk++; if (done_t.size() !== 1) $display("FAIL loop_done_cnt: got %0d want 1", done_t.size()); else n_pass++;
    n_chk++; if (bfall_t.size() !== 1 || bfall_t[0] !== e + 2*F*D + 2*D)
      $display("FAIL loop_busy_fall: got %0d want %0d", bfall_t.size() ? bfall_t[0] : -1, e + 2*F*D + 2*D);
    else n_pass++;
  endtask

  task automatic test_random_frames();
    int e, te, me;
    logic [F-1:0] tx;
    loop = 1'b0;
    for (int it = 0; it < 4; it++) begin
      tx       = F'($urandom);
      miso_vec = F'($urandom);
      clear_mon();
      send_frame(tx, e);
      te = timing_errs(e, 0);
      me = mosi_errs(tx, 0);
      n_chk++; if (te !== 0) $display("FAIL rand_timing[%0d]: %0d events off", it, te); else n_pass++;
      n_chk++; if (me !== 0) $display("FAIL rand_mosi[%0d]: %0d bits wrong tx=%h", it, me, tx); else n_pass++;
      n_chk++; if (rx_data !== exp_rx(tx, miso_vec, 1'b0))
        $display("FAIL rand_rx[%0d]: got %h want %h", it, rx_data, exp_rx(tx, miso_vec, 1'b0)); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int e1, e2, gap;
    logic [F-1:0] t1, t2;
    loop = 1'b1;
    t1 = F'($urandom);
    t2 = ~t1;
    clear_mon();
    @(negedge clk);
    tx_data = t1;
    start   = 1'b1;
    e1      = cyc + 1;
    @(negedge clk);
    tx_data = t2;
    e2 = e1 + 2*F*D + 2*D;
    while (cyc < e2) @(negedge clk);
    start = 1'b0;
    repeat (2*F*D + 2*D + 4) @(negedge clk);
    gap = (lo_t.size() > 1 && hi_t.size() > 0) ? lo_t[1] - hi_t[0] : -1;
    n_chk++; if (timing_errs(e1, 0) !== 0) $display("FAIL b2b_timing1: %0d events off", timing_errs(e1, 0)); else n_pass++;
    n_chk++; if (timing_errs(e2, 1) !== 0) $display("FAIL b2b_timing2: %0d events off", timing_errs(e2, 1)); else n_pass++;
    n_chk++; if (mosi_errs(t1, 0) !== 0) $display("FAIL b2b_mosi1: %0d bits wrong", mosi_errs(t1, 0)); else n_pass++;
    n_chk++; if (mosi_errs(t2, 1) !== 0) $display("FAIL b2b_mosi2: %0d bits wrong", mosi_errs(t2, 1)); else n_pass++;
    n_chk++; if (gap !== D) $display("FAIL b2b_gap: got %0d cycles want %0d", gap, D); else n_pass++;
    n_chk++; if (done_t.size() !== 2) $display("FAIL b2b_done_cnt: got %0d want 2", done_t.size()); else n_pass++;
    n_chk++; if (bfall_t.size() !== 1) $display("FAIL b2b_busy_falls: got %0d want 1", bfall_t.size()); else n_pass++;
    n_chk++; if (rx_data !== exp_rx(t2, '0, 1'b1))
      $display("FAIL b2b_rx: got %h want %h", rx_data, exp_rx(t2, '0, 1'b1)); else n_pass++;
  endtask

  task automatic test_ignore_start();
    int e;
    logic [F-1:0] t1;
    loop = 1'b1;
    t1 = F'($urandom);
    clear_mon();
    @(negedge clk);
    tx_data = t1;
    start   = 1'b1;
    e       = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    tx_data = ~t1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4*F*D + 4*D) @(negedge clk);
    n_chk++; if (timing_errs(e, 0) !== 0) $display("FAIL ign_timing: %0d events off", timing_errs(e, 0)); else n_pass++;
    n_chk++; if (mosi_errs(t1, 0) !== 0) $display("FAIL ign_mosi: %0d bits wrong", mosi_errs(t1, 0)); else n_pass++;
    n_chk++; if (done_t.size() !== 1) $display("FAIL ign_done_cnt: got %0d want 1", done_t.size()); else n_pass++;
    n_chk++; if (lo_t.size() !== 1) $display("FAIL ign_frames: got %0d want 1", lo_t.size()); else n_pass++;
    n_chk++; if (rx_data !== exp_rx(t1, '0, 1'b1))
      $display("FAIL ign_rx: got %h want %h", rx_data, exp_rx(t1, '0, 1'b1)); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int e;
    bit got = 1'b0;
    logic [F-1:0] t1, t2;
    loop = 1'b0;
    miso_vec = F'($urandom);
    t1 = F'($urandom);
    t2 = F'($urandom);
    clear_mon();
    @(negedge clk);
    tx_data = t1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      #1;
      if (rise_t.size() >= 4) got = 1'b1;
    end
    n_chk++; if (!got) $display("FAIL rstmid_rise3: rise 3 not seen, rises=%0d want 4", rise_t.size()); else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++; if (ssel !== 1'b1) $display("FAIL rstmid_ssel: got %b want 1", ssel); else n_pass++;
    n_chk++; if (sck !== 1'b0)  $display("FAIL rstmid_sck: got %b want 0", sck);   else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2*F*D) @(negedge clk);
    n_chk++; if (done_t.size() !== 0) $display("FAIL rstmid_no_done: got %0d pulses want 0", done_t.size()); else n_pass++;
    n_chk++; if (rx_data !== '0) $display("FAIL rstmid_rx_cleared: got %h want 0", rx_data); else n_pass++;
    clear_mon();
    send_frame(t2, e);
    n_chk++; if (timing_errs(e, 0) !== 0) $display("FAIL rstmid_timing: %0d events off", timing_errs(e, 0)); else n_pass++;
    n_chk++; if (mosi_errs(t2, 0) !== 0) $display("FAIL rstmid_mosi: %0d bits wrong", mosi_errs(t2, 0)); else n_pass++;
    n_chk++; if (rx_data !== exp_rx(t2, miso_vec, 1'b0))
      $display("FAIL rstmid_rx: got %h want %h", rx_data, exp_rx(t2, miso_vec, 1'b0)); else n_pass++;
  endtask

  task automatic test_long_frame();
    logic [39:0] exp_hi;
    exp_hi = 40'h5555555555;
`ifndef SPI_MASTER_RX_EN
    exp_hi = '0;
`endif
    mv88     = {40'h5555555555, 48'h0};
    done88_n = 0;
    @(negedge clk);
    tx88    = 88'hFF00FF00FF00FF00FF00FF;
    start88 = 1'b1;
    @(negedge clk);
    start88 = 1'b0;
    tx88    = '0;
    repeat (2*FL*D + 2*D + 6) @(negedge clk);
    n_chk++; if (nr88 !== FL) $display("FAIL long_rises: got %0d want %0d", nr88, FL); else n_pass++;
    n_chk++; if (mosi88_acc !== 88'hFF00FF00FF00FF00FF00FF)
      $display("FAIL long_mosi: got %h want FF00FF00FF00FF00FF00FF", mosi88_acc); else n_pass++;
    n_chk++; if (rx88[87:48] !== exp_hi) $display("FAIL long_rx_hi: got %h want %h", rx88[87:48], exp_hi); else n_pass++;
    n_chk++; if (rx88[47:0] !== 48'h0) $display("FAIL long_rx_lo: got %h want 0", rx88[47:0]); else n_pass++;
    n_chk++; if (done88_n !== 1) $display("FAIL long_done_cnt: got %0d want 1", done88_n); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_random_frames();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_long_frame();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 88, bits per SSEL frame (legal 8..128).
REQ-002 SHALL have parameter CLK_DIV, default 4, clk cycles per SCK half-period (legal 4..255).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port start  input  1  frame request, sampled only while idle.
REQ-006 SHALL have port tx_data  input  FRAME_BITS  frame to send, MSB first.
REQ-007 SHALL have port busy  output  1  high from frame acceptance through end of inter-frame gap.
REQ-008 SHALL have port done  output  1  one-cycle pulse when frame complete.
REQ-009 SHALL have port rx_data  output  FRAME_BITS  bits captured from MISO, MSB first.
REQ-010 SHALL have ports SCK, MOSI, SSEL  output  1 each, and MISO  input  1: SPI bus, SSEL active low, SCK idle low.

Function
REQ-011 SHALL implement FSM IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
REQ-012 IDLE: start=1 at edge t0 SHALL latch tx_data; at t0+1 SSEL=0, busy=1, MOSI=tx_data[FRAME_BITS-1], state SETUP.
REQ-013 SETUP SHALL last CLK_DIV cycles with SCK=0.
REQ-014 SHIFT: rising SCK edge k (k=0..FRAME_BITS-1) SHALL occur at t0+1+CLK_DIV+2k*CLK_DIV; falling edge k at t0+1+2(k+1)*CLK_DIV.
REQ-015 MISO SHALL be captured at the clk edge that drives SCK high (value before the rise), shifted into rx shift register LSB.
REQ-016 MOSI SHALL advance to the next bit on each falling SCK edge except the last; after the last falling edge MOSI holds the final bit.
REQ-017 HOLD: SSEL SHALL stay low CLK_DIV cycles after the last falling edge, then go high.
REQ-018 On the cycle SSEL goes high, done SHALL pulse 1 cycle and rx_data SHALL update with the full frame; rx_data otherwise holds.
REQ-019 GAP SHALL keep SSEL high and busy=1 for CLK_DIV cycles, then busy=0, state IDLE.
REQ-020 start while busy SHALL be ignored; tx_data changes after acceptance SHALL not affect the frame.
REQ-021 start asserted on the cycle busy falls SHALL be accepted (back-to-back frames, gap exactly CLK_DIV cycles of SSEL high).
REQ-022 Bit counter SHALL be ceil(log2(FRAME_BITS+1)) bits; divider counter 8 bits; no wrap beyond FRAME_BITS.

Reset
REQ-023 rst=1 SHALL asynchronously force IDLE, SCK=0, SSEL=1, MOSI=0, busy=0, done=0, rx_data=0, counters 0.
REQ-024 rst mid-frame SHALL abort immediately (SSEL high, no done pulse); the next frame after release starts cleanly from REQ-012.

Configuration
REQ-025 Macro SPI_MASTER_RX_EN defined: MISO capture per REQ-015/018.
REQ-026 Macro SPI_MASTER_RX_EN undefined: no rx shift register, rx_data constant 0, MISO unused; all timing identical.

Structure
REQ-027 Package spi_pkg SHALL hold the FSM state enum (IDLE, SETUP, SHIFT, HOLD, GAP) and the default FRAME_BITS/CLK_DIV constants.
REQ-028 Sub-module spi_clk_gen SHALL generate SCK and one-cycle rise/fall strobes from CLK_DIV, enabled by the FSM.

Verification
REQ-029 FRAME_BITS=8, CLK_DIV=4, tx_data=0xA5, MISO looped to MOSI -> MOSI bits 1,0,1,0,0,1,0,1 at rises; rx_data=0xA5; done at t0+1+64+4.
REQ-030 Defaults, tx_data=88'hFF00..., slave model returning 40'h5555555555 then zeros -> rx_data[87:48]=40'h5555555555, exactly 88 SCK rises.
REQ-031 start held high continuously for two frames -> SSEL high exactly 4 cycles between frames, second frame identical timing.
REQ-032 start pulsed mid-frame with different tx_data -> ignored; transmitted frame unchanged, single done.
REQ-033 rst asserted at SCK rise 3 -> SSEL=1, SCK=0, busy=0 in same cycle, no done; new frame after release transmits correctly.
REQ-034 Build without SPI_MASTER_RX_EN, MISO toggling -> rx_data stays 0, SCK/MOSI/SSEL waveforms identical to REQ-029.
